fe_ctrl: RTL and testbench
==========================

Name: fe_ctrl

Overview:
Sequencer and result collector for the frequency estimator (fe) datapath.
- Sequencing: enables fe, waits out its static pipeline latency (warm-up), then forwards a decimated subset of upstream frame-valid strobes to fe.
- Result collection: tracks frames still in flight, watchdogs fe results, and averages 2^k fo estimates into one output value for the downstream carrier-recovery loop.
- Placement: between the framing/valid source and the fe instance, one per lane.

Parameters:
- MAX_OUTST, 8, maximum fe frames in flight (outstanding counter width = clog2(MAX_OUTST+1)).
- TO_MARGIN, 16, extra cycles beyond i_pipe_lat before a missing fe result is an error.
- FO_W, 15, fe estimate width (signed two's complement).

Ports:
- clk  in  1  system clock.
- rst_sync  in  1  synchronous active-high reset.
- i_start  in  1  pulse; start a run (ignored unless IDLE).
- i_stop  in  1  pulse; end a run.
- i_valid  in  1  upstream frame-valid strobe.
- i_subsampling  in  1  fe subsampling mode; latched at start.
- i_decim  in  4  forward 1 of every i_decim+1 valid frames; latched at start.
- i_avg_log2  in  3  k; average 2^k estimates (0..7); latched at start.
- i_pipe_lat  in  10  fe pipeline latency in cycles; latched at start.
- o_fe_enable  out  1  to fe i_enable.
- o_fe_valid  out  1  to fe i_valid.
- o_fe_subsampling  out  1  to fe i_subsampling.
- i_fo_valid  in  1  from fe o_fo_valid.
- i_fo_value  in  15  from fe o_fo_value.
- o_avg_valid  out  1  one-cycle pulse, average ready.
- o_avg_value  out  15  signed average.
- o_busy  out  1  state != IDLE.
- o_drop  out  1  pulse; selected frame suppressed because MAX_OUTST frames are in flight.
- o_err  out  1  sticky; timeout or spurious result; cleared by i_start.

Behaviour:
Reset:
- All outputs 0; state IDLE; all counters and accumulator 0.
- A reset asserted mid-run aborts immediately, with no drain.

States:
- IDLE:
  - o_fe_enable=0.
  - i_start: latch cfg, clear o_err, -> WARMUP.
- WARMUP:
  - o_fe_enable=1, o_fe_valid=0.
  - Count i_pipe_lat cycles, then -> RUN. i_pipe_lat=0 gives a 1-cycle WARMUP.
  - i_stop -> DRAIN.
- RUN:
  - Decim counter counts i_valid strobes 0..i_decim and wraps to 0.
  - A strobe arriving while the counter is 0 is selected.
  - Selected strobe with outstanding < MAX_OUTST: o_fe_valid=1 on the next cycle (registered, 1-cycle latency; the external data register matches this).
  - Selected strobe at outstanding == MAX_OUTST: no o_fe_valid; o_drop pulses 1 cycle later.
  - i_stop -> DRAIN; i_valid arriving in the i_stop cycle is ignored.
- DRAIN:
  - No new o_fe_valid; o_fe_enable stays 1.
  - outstanding == 0 -> IDLE.
- i_start is ignored in any state other than IDLE.

Outstanding counter:
- Increments on o_fe_valid, decrements on i_fo_valid.
- Both in the same cycle: counter unchanged.
- i_fo_valid while outstanding == 0: spurious; set o_err, counter stays 0, value discarded.

Watchdog:
- Reloads on each o_fe_valid issued while outstanding == 0, and on each i_fo_valid; runs while outstanding > 0.
- Reaching i_pipe_lat+TO_MARGIN sets o_err and clears outstanding. In DRAIN this then exits to IDLE.

Averaging:
- 22-bit signed accumulator (FO_W+7) and 8-bit sample counter.
- Each accepted i_fo_valid adds the sign-extended value.
- On the 2^k-th sample:
  - o_avg_value = acc_next >>> k (arithmetic shift, floor), low 15 bits.
  - o_avg_valid pulses 1 cycle after that i_fo_valid.
  - Accumulator and counter clear.
- Partial accumulation is discarded on exit to IDLE.
- o_avg_value holds its last value between pulses.

Decomposition:
- Package fe_ctrl_pkg: state enum (IDLE, WARMUP, RUN, DRAIN), FO_W, ACC_W=FO_W+7, localparams for counter widths.
- Sub-module fe_avg_acc: accumulate/shift/pulse logic with ports clear, in_valid, in_value, k, out_valid, out_value.
- The FSM, decimator, outstanding counter and watchdog stay in fe_ctrl.

Test Plan:
1. pipe_lat=5, decim=0, k=0; i_start then continuous i_valid; fe model echoes 0x0010 after 5 cycles -> o_fe_enable at start+1, first o_fe_valid 1 cycle after WARMUP ends, o_avg_value=0x0010 per result.
2. decim=2, 9 i_valid strobes in RUN -> exactly 3 o_fe_valid, on strobes 1, 4 and 7.
3. k=2, results -3, -2, 5, 1 -> one o_avg_valid with o_avg_value=0x0000 (sum 1 >>> 2); results -1,-1,-1,-2 -> 0x7FFE (-2, floor of -1.25).
4. MAX_OUTST=8, fe withholds results, 10 selected strobes -> 8 o_fe_valid, 2 o_drop pulses; release results -> outstanding returns to 0.
5. fe never responds, pipe_lat=5 -> o_err=1 exactly 21 cycles after the first o_fe_valid; i_stop -> DRAIN -> IDLE; next i_start clears o_err.
6. Spurious i_fo_valid in IDLE -> o_err=1, no o_avg_valid. i_stop during WARMUP -> IDLE with zero o_fe_valid. rst_sync mid-RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/fe_ctrl_pkg.sv
// Shared widths and state encodings for the frequency-estimator sequencer.
package fe_ctrl_pkg;

    localparam int FO_W      = 15;
    localparam int ACC_W     = FO_W + 7;
    localparam int AVG_CNT_W = 8;
    localparam int K_W       = 3;
    localparam int DEC_W     = 4;
    localparam int LAT_W     = 10;
    localparam int WD_W      = LAT_W + 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WARMUP = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

endpackage

// File: rtl/fe_ctrl_if.sv
// Link between the sequencer (master) and the fe datapath (slave).
interface fe_ctrl_if;
    import fe_ctrl_pkg::*;

    logic            o_fe_enable;
    logic            o_fe_valid;
    logic            o_fe_subsampling;
    logic            i_fo_valid;
    logic [FO_W-1:0] i_fo_value;

    modport master (
        output o_fe_enable, o_fe_valid, o_fe_subsampling,
        input  i_fo_valid, i_fo_value
    );

    modport slave (
        input  o_fe_enable, o_fe_valid, o_fe_subsampling,
        output i_fo_valid, i_fo_value
    );

endinterface

// File: rtl/fe_avg_acc.sv
// Averages 2^k signed fo estimates; pulses the floored mean one cycle after the last sample.
module fe_avg_acc
    import fe_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_sync,
    input  logic            i_clear,
    input  logic            i_in_valid,
    input  logic [FO_W-1:0] i_in_value,
    input  logic [K_W-1:0]  i_k,
    output logic            o_out_valid,
    output logic [FO_W-1:0] o_out_value
);

    logic signed [ACC_W-1:0]     r_acc;
    logic [AVG_CNT_W-1:0]        r_cnt;
    logic                        r_out_valid;
    logic [FO_W-1:0]             r_out_value;

    logic signed [ACC_W-1:0]     w_acc_next;
    logic [AVG_CNT_W-1:0]        w_cnt_next;
    logic [AVG_CNT_W-1:0]        w_target;
    logic [FO_W-1:0]             w_avg;
    logic                        w_done;

    always_comb begin
        w_acc_next = r_acc + {{(ACC_W-FO_W){i_in_value[FO_W-1]}}, i_in_value};
        w_cnt_next = r_cnt + AVG_CNT_W'(1);
        w_target   = AVG_CNT_W'(1) << i_k;
        w_done     = i_in_valid && (w_cnt_next == w_target);
        // Arithmetic shift floors toward minus infinity, then keep the low FO_W bits.
        w_avg      = FO_W'(w_acc_next >>> i_k);
    end

    // A completing sample still publishes even if the run is being torn down this cycle.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_value <= '0;
        end else begin
            r_out_valid <= w_done;
            if (w_done) begin
                r_out_value <= w_avg;
            end
            if (i_clear || w_done) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (i_in_valid) begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_next;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_value = r_out_value;

endmodule

// File: rtl/fe_ctrl.sv
// Sequencer and result collector for one fe lane: warm-up, decimated issue,
// in-flight tracking with watchdog, and 2^k averaging of fo estimates.
//   state  | meaning
//   IDLE   | fe disabled, waiting for i_start
//   WARMUP | fe enabled, waiting out its pipeline latency
//   RUN    | forwarding every (decim+1)-th valid strobe to fe
//   DRAIN  | no new issues, waiting for in-flight results
module fe_ctrl
    import fe_ctrl_pkg::*;
#(
    parameter int MAX_OUTST = 8,
    parameter int TO_MARGIN = 16
)(
    input  logic              clk,
    input  logic              rst_sync,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_valid,
    input  logic              i_subsampling,
    input  logic [DEC_W-1:0]  i_decim,
    input  logic [K_W-1:0]    i_avg_log2,
    input  logic [LAT_W-1:0]  i_pipe_lat,
    fe_ctrl_if.master         fe,
    output logic              o_avg_valid,
    output logic [FO_W-1:0]   o_avg_value,
    output logic              o_busy,
    output logic              o_drop,
    output logic              o_err
);

    localparam int OUT_W = $clog2(MAX_OUTST + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTST);

    logic [1:0]       r_state;
    logic [DEC_W-1:0] r_decim;
    logic [K_W-1:0]   r_k;
    logic [LAT_W-1:0] r_lat;
    logic             r_sub;
    logic [LAT_W-1:0] r_timer;
    logic [DEC_W-1:0] r_dcnt;
    logic [OUT_W-1:0] r_outst;
    logic [WD_W-1:0]  r_wdog;
    logic             r_fe_valid;
    logic             r_drop;
    logic             r_err;

    logic [1:0]       w_state_next;
    logic [OUT_W-1:0] w_outst_next;
    logic [WD_W-1:0]  w_wd_limit;
    logic             w_fo_acc;
    logic             w_spurious;
    logic             w_wd_reload;
    logic             w_timeout;
    logic             w_sel;
    logic             w_issue;
    logic             w_drop;
    logic             w_avg_clear;

    always_comb begin
        w_fo_acc    = fe.i_fo_valid && (r_outst != '0);
        w_spurious  = fe.i_fo_valid && (r_outst == '0);
        w_wd_reload = (r_fe_valid && (r_outst == '0)) || w_fo_acc;
        w_timeout   = (r_outst != '0) && !w_wd_reload && (r_wdog == '0);
        // Reload two short so the error lands exactly pipe_lat+TO_MARGIN cycles after the reload.
        w_wd_limit  = WD_W'(r_lat) + WD_W'(TO_MARGIN) - WD_W'(2);

        w_outst_next = r_outst;
        if (w_timeout) begin
            w_outst_next = '0;
        end else if (r_fe_valid && !w_fo_acc) begin
            w_outst_next = r_outst + OUT_W'(1);
        end else if (!r_fe_valid && w_fo_acc) begin
            w_outst_next = r_outst - OUT_W'(1);
        end

        // Compare against the post-update count so a pending registered issue is included.
        w_sel   = (r_state == ST_RUN) && !i_stop && i_valid && (r_dcnt == '0);
        w_issue = w_sel && (w_outst_next < OUT_MAX);
        w_drop  = w_sel && !(w_outst_next < OUT_MAX);

        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (i_start) w_state_next = ST_WARMUP;
            ST_WARMUP: begin
                if (i_stop)              w_state_next = ST_DRAIN;
                else if (r_timer == '0)  w_state_next = ST_RUN;
            end
            ST_RUN:    if (i_stop) w_state_next = ST_DRAIN;
            ST_DRAIN:  if (w_outst_next == '0) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase

        w_avg_clear = (r_state != ST_IDLE) && (w_state_next == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_state    <= ST_IDLE;
            r_decim    <= '0;
            r_k        <= '0;
            r_lat      <= '0;
            r_sub      <= 1'b0;
            r_timer    <= '0;
            r_dcnt     <= '0;
            r_outst    <= '0;
            r_wdog     <= '0;
            r_fe_valid <= 1'b0;
            r_drop     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_outst    <= w_outst_next;
            r_fe_valid <= w_issue;
            r_drop     <= w_drop;

            if (w_wd_reload) begin
                r_wdog <= w_wd_limit;
            end else if ((r_outst != '0) && (r_wdog != '0)) begin
                r_wdog <= r_wdog - WD_W'(1);
            end

            if (w_spurious || w_timeout) begin
                r_err <= 1'b1;
            end else if ((r_state == ST_IDLE) && i_start) begin
                r_err <= 1'b0;
            end

            if ((r_state == ST_IDLE) && i_start) begin
                r_decim <= i_decim;
                r_k     <= i_avg_log2;
                r_lat   <= i_pipe_lat;
                r_sub   <= i_subsampling;
                r_timer <= i_pipe_lat;
                r_dcnt  <= '0;
            end

            if ((r_state == ST_WARMUP) && (r_timer != '0)) begin
                r_timer <= r_timer - LAT_W'(1);
            end

            if ((r_state == ST_RUN) && i_valid && !i_stop) begin
                r_dcnt <= (r_dcnt == r_decim) ? '0 : r_dcnt + DEC_W'(1);
            end
        end
    end

    fe_avg_acc u_avg (
        .clk         (clk),
        .rst_sync    (rst_sync),
        .i_clear     (w_avg_clear),
        .i_in_valid  (w_fo_acc),
        .i_in_value  (fe.i_fo_value),
        .i_k         (r_k),
        .o_out_valid (o_avg_valid),
        .o_out_value (o_avg_value)
    );

    assign fe.o_fe_enable      = (r_state != ST_IDLE);
    assign fe.o_fe_valid       = r_fe_valid;
    assign fe.o_fe_subsampling = r_sub;
    assign o_busy              = (r_state != ST_IDLE);
    assign o_drop              = r_drop;
    assign o_err               = r_err;

endmodule

// File: tb/tb_fe_ctrl.sv
// Directed bench for fe_ctrl with a simple 5-cycle echo model of the fe datapath.
module tb_fe_ctrl;

    logic        clk = 1'b0;
    logic        rst_sync, i_start, i_stop, i_valid, i_subsampling;
    logic [3:0]  i_decim;
    logic [2:0]  i_avg_log2;
    logic [9:0]  i_pipe_lat;
    logic        o_avg_valid, o_busy, o_drop, o_err;
    logic [14:0] o_avg_value;

    logic        tb_fo_valid, echo_en;
    logic [14:0] tb_fo_value, echo_val;
    logic [4:0]  r_echo = '0;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    fe_ctrl_if fe_bus();

    always @(posedge clk) r_echo <= {r_echo[3:0], fe_bus.o_fe_valid & echo_en};
    assign fe_bus.i_fo_valid = tb_fo_valid | (echo_en & r_echo[4]);
    assign fe_bus.i_fo_value = echo_en ? echo_val : tb_fo_value;

    fe_ctrl #(.MAX_OUTST(8), .TO_MARGIN(16)) dut (
        .clk           (clk),
        .rst_sync      (rst_sync),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_valid       (i_valid),
        .i_subsampling (i_subsampling),
        .i_decim       (i_decim),
        .i_avg_log2    (i_avg_log2),
        .i_pipe_lat    (i_pipe_lat),
        .fe            (fe_bus.master),
        .o_avg_valid   (o_avg_valid),
        .o_avg_value   (o_avg_value),
        .o_busy        (o_busy),
        .o_drop        (o_drop),
        .o_err         (o_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && o_busy; i++) step();
    endtask

    task automatic test_reset();
        rst_sync = 1'b1;
        repeat (3) step();
        n_checks++; if (fe_bus.o_fe_enable !== 1'b0) begin n_err++; $display("FAIL rst_enable: got=%b exp=0", fe_bus.o_fe_enable); end
        n_checks++; if (fe_bus.o_fe_valid !== 1'b0) begin n_err++; $display("FAIL rst_fe_valid: got=%b exp=0", fe_bus.o_fe_valid); end
        n_checks++; if (o_avg_value !== 15'h0) begin n_err++; $display("FAIL rst_avg_value: got=%h exp=0", o_avg_value); end
        n_checks++; if ({o_busy, o_err, o_drop, o_avg_valid, fe_bus.o_fe_subsampling} !== 5'b0) begin
            n_err++; $display("FAIL rst_flags: got=%b exp=00000", {o_busy, o_err, o_drop, o_avg_valid, fe_bus.o_fe_subsampling});
        end
        rst_sync = 1'b0;
        step();
    endtask

    task automatic test_sequencing();
        int first_fev = -1;
        int first_avg = -1;
        int drops = 0;
        logic [14:0] v_first = '0;
        i_pipe_lat = 10'd5; i_decim = 4'd0; i_avg_log2 = 3'd0; i_subsampling = 1'b1;
        echo_en = 1'b1; echo_val = 15'h0010; i_valid = 1'b1;
        i_start = 1'b1; step(); i_start = 1'b0;
        n_checks++; if (fe_bus.o_fe_enable !== 1'b1) begin n_err++; $display("FAIL seq_enable: got=%b exp=1", fe_bus.o_fe_enable); end
        n_checks++; if (fe_bus.o_fe_subsampling !== 1'b1) begin n_err++; $display("FAIL seq_subsampling: got=%b exp=1", fe_bus.o_fe_subsampling); end
        for (int n = 1; n <= 16; n++) begin
            if (fe_bus.o_fe_valid && first_fev < 0) first_fev = n;
            if (o_avg_valid && first_avg < 0) begin first_avg = n; v_first = o_avg_value; end
            if (o_drop) drops++;
            step();
        end
        n_checks++; if (first_fev !== 8) begin n_err++; $display("FAIL seq_first_fe_valid: got=%0d exp=8", first_fev); end
        n_checks++; if (first_avg !== 14) begin n_err++; $display("FAIL seq_first_avg: got=%0d exp=14", first_avg); end
        n_checks++; if (v_first !== 15'h0010) begin n_err++; $display("FAIL seq_avg_value: got=%h exp=0010", v_first); end
        n_checks++; if ({o_avg_valid, o_avg_value} !== {1'b1, 15'h0010}) begin n_err++; $display("FAIL seq_avg_stream: got=%b/%h exp=1/0010", o_avg_valid, o_avg_value); end
        n_checks++; if (drops !== 0) begin n_err++; $display("FAIL seq_drops: got=%0d exp=0", drops); end
        i_valid = 1'b0; i_stop = 1'b1; step(); i_stop = 1'b0;
        wait_idle();
        n_checks++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL seq_drain: got busy=%b exp=0", o_busy); end
        n_checks++; if (o_err !== 1'b0) begin n_err++; $display("FAIL seq_err: got=%b exp=0", o_err); end
    endtask

    task automatic test_decimation();
        int fev = 0;
        logic exp_v;
        i_pipe_lat = 10'd0; i_decim = 4'd2; i_avg_log2 = 3'd0; i_subsampling = 1'b0;
        echo_en = 1'b1; echo_val = 15'h0001; i_valid = 1'b0;
        i_start = 1'b1; step(); i_start = 1'b0;
        step();
        for (int j = 0; j < 9; j++) begin
            i_valid = 1'b1; step(); i_valid = 1'b0;
            exp_v = (j % 3 == 0);
            n_checks++; if (fe_bus.o_fe_valid !== exp_v) begin n_err++; $display("FAIL decim_strobe%0d: got=%b exp=%b", j + 1, fe_bus.o_fe_valid, exp_v); end
            if (fe_bus.o_fe_valid) fev++;
            step();
        end
        n_checks++; if (fev !== 3) begin n_err++; $display("FAIL decim_count: got=%0d exp=3", fev); end
        n_checks++; if (fe_bus.o_fe_subsampling !== 1'b0) begin n_err++; $display("FAIL decim_subsampling: got=%b exp=0", fe_bus.o_fe_subsampling); end
        i_stop = 1'b1; step(); i_stop = 1'b0;
        wait_idle();
        n_checks++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL decim_drain: got busy=%b exp=0", o_busy); end
    endtask

    task automatic test_averaging();
        logic [14:0] vals [8] = '{15'h7FFD, 15'h7FFE, 15'h0005, 15'h0001,
                                  15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFE};
        logic [14:0] exp_avg [2] = '{15'h0000, 15'h7FFE};
        i_pipe_lat = 10'd0; i_decim = 4'd0; i_avg_log2 = 3'd2;
        echo_en = 1'b0; tb_fo_valid = 1'b0;
        i_start = 1'b1; step(); i_start = 1'b0;
        step();
        for (int b = 0; b < 2; b++) begin
            i_valid = 1'b1; repeat (4) step(); i_valid = 1'b0;
            step();
            for (int i = 0; i < 4; i++) begin
                tb_fo_valid = 1'b1; tb_fo_value = vals[b*4+i]; step(); tb_fo_valid = 1'b0;
                n_checks++; if (o_avg_valid !== (i == 3)) begin n_err++; $display("FAIL avg_pulse_b%0d_s%0d: got=%b exp=%b", b, i, o_avg_valid, (i == 3)); end
            end
            n_checks++; if (o_avg_value !== exp_avg[b]) begin n_err++; $display("FAIL avg_value_b%0d: got=%h exp=%h", b, o_avg_value, exp_avg[b]); end
        end
        step();
        n_checks++; if ({o_avg_valid, o_avg_value} !== {1'b0, 15'h7FFE}) begin n_err++; $display("FAIL avg_hold: got=%b/%h exp=0/7ffe", o_avg_valid, o_avg_value); end
        n_checks++; if (o_err !== 1'b0) begin n_err++; $display("FAIL avg_err: got=%b exp=0", o_err); end
        i_stop = 1'b1; step(); i_stop = 1'b0;
        wait_idle();
    endtask

    task automatic test_drop();
        int fev = 0;
        int drops = 0;
        i_pipe_lat = 10'd10; i_decim = 4'd0; i_avg_log2 = 3'd0;
        echo_en = 1'b0; tb_fo_valid = 1'b0;
        i_start = 1'b1; step(); i_start = 1'b0;
        repeat (11) step();
        i_valid = 1'b1;
        for (int n = 0; n < 13; n++) begin
            if (n == 10) i_valid = 1'b0;
            step();
            if (fe_bus.o_fe_valid) fev++;
            if (o_drop) drops++;
        end
        n_checks++; if (fev !== 8) begin n_err++; $display("FAIL drop_fe_valid_count: got=%0d exp=8", fev); end
        n_checks++; if (drops !== 2) begin n_err++; $display("FAIL drop_pulses: got=%0d exp=2", drops); end
        for (int r = 0; r < 8; r++) begin
            tb_fo_valid = 1'b1; tb_fo_value = 15'(r); step();
        end
        tb_fo_valid = 1'b0;
        n_checks++; if (o_err !== 1'b0) begin n_err++; $display("FAIL drop_release_err: got=%b exp=0", o_err); end
        i_stop = 1'b1; step(); i_stop = 1'b0;
        step();
        n_checks++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL drop_outstanding_zero: got busy=%b exp=0", o_busy); end
        wait_idle();
    endtask

    task automatic test_timeout();
        i_pipe_lat = 10'd5; i_decim = 4'd0; i_avg_log2 = 3'd0;
        echo_en = 1'b0; tb_fo_valid = 1'b0;
        i_start = 1'b1; step(); i_start = 1'b0;
        repeat (6) step();
        i_valid = 1'b1; step(); i_valid = 1'b0;
        n_checks++; if (fe_bus.o_fe_valid !== 1'b1) begin n_err++; $display("FAIL to_issue: got=%b exp=1", fe_bus.o_fe_valid); end
        for (int n = 1; n <= 21; n++) begin
            step();
            if (n == 20) begin
                n_checks++; if (o_err !== 1'b0) begin n_err++; $display("FAIL to_early: got=%b exp=0", o_err); end
            end
        end
        n_checks++; if (o_err !== 1'b1) begin n_err++; $display("FAIL to_at_21: got=%b exp=1", o_err); end
        i_stop = 1'b1; step(); i_stop = 1'b0;
        step();
        n_checks++; if ({o_busy, o_err} !== 2'b01) begin n_err++; $display("FAIL to_drain_idle: got busy/err=%b exp=01", {o_busy, o_err}); end
        i_start = 1'b1; step(); i_start = 1'b0;
        n_checks++; if ({o_busy, o_err} !== 2'b10) begin n_err++; $display("FAIL to_restart_clear: got busy/err=%b exp=10", {o_busy, o_err}); end
        i_stop = 1'b1; step(); i_stop = 1'b0;
        wait_idle();
    endtask

    task automatic test_misc();
        int fev = 0;
        echo_en = 1'b0;
        tb_fo_valid = 1'b1; tb_fo_value = 15'h0123; step(); tb_fo_valid = 1'b0;
        n_checks++; if ({o_err, o_avg_valid} !== 2'b10) begin n_err++; $display("FAIL spur_err: got err/avg=%b exp=10", {o_err, o_avg_valid}); end
        step();
        n_checks++; if (o_avg_valid !== 1'b0) begin n_err++; $display("FAIL spur_no_avg: got=%b exp=0", o_avg_valid); end

        i_pipe_lat = 10'd10; i_valid = 1'b1;
        i_start = 1'b1; step(); i_start = 1'b0;
        n_checks++; if (o_err !== 1'b0) begin n_err++; $display("FAIL warm_err_clear: got=%b exp=0", o_err); end
        repeat (2) step();
        i_stop = 1'b1; step(); i_stop = 1'b0;
        for (int n = 0; n < 15; n++) begin
            if (fe_bus.o_fe_valid) fev++;
            step();
        end
        i_valid = 1'b0;
        n_checks++; if (fev !== 0) begin n_err++; $display("FAIL warm_stop_fe_valid: got=%0d exp=0", fev); end
        n_checks++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL warm_stop_idle: got busy=%b exp=0", o_busy); end

        i_pipe_lat = 10'd0; i_decim = 4'd0; i_avg_log2 = 3'd0; i_subsampling = 1'b1;
        echo_en = 1'b1; echo_val = 15'h0010; i_valid = 1'b1;
        i_start = 1'b1; step(); i_start = 1'b0;
        repeat (12) step();
        n_checks++; if (o_avg_valid !== 1'b1) begin n_err++; $display("FAIL rst_run_active: got avg_valid=%b exp=1", o_avg_valid); end
        rst_sync = 1'b1; echo_en = 1'b0; step();
        n_checks++; if ({fe_bus.o_fe_enable, fe_bus.o_fe_valid, fe_bus.o_fe_subsampling, o_avg_valid, o_busy, o_drop, o_err} !== 7'b0) begin
            n_err++; $display("FAIL rst_mid_run_flags: got=%b exp=0000000",
                {fe_bus.o_fe_enable, fe_bus.o_fe_valid, fe_bus.o_fe_subsampling, o_avg_valid, o_busy, o_drop, o_err});
        end
        n_checks++; if (o_avg_value !== 15'h0) begin n_err++; $display("FAIL rst_mid_run_avg: got=%h exp=0", o_avg_value); end
        rst_sync = 1'b0; i_valid = 1'b0;
        step();
    endtask

    initial begin
        rst_sync = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_valid = 1'b0; i_subsampling = 1'b0;
        i_decim = '0; i_avg_log2 = '0; i_pipe_lat = '0;
        tb_fo_valid = 1'b0; tb_fo_value = '0; echo_en = 1'b0; echo_val = '0;
        test_reset();
        test_sequencing();
        test_decimation();
        test_averaging();
        test_drop();
        test_timeout();
        test_misc();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
